// File: rtl/linear_tile_ctrl.sv
// linear_tile_ctrl: tile controller for the int8 linear layer OUT = X * W.
// Walks the output in TxT tiles (T = WIDTH/8). For each tile it streams K_DIM
// activation/weight words into an external systolic array, waits for the
// array to drain, then requantises and writes the tile back as transposed
// int8 rows through the weight bar.
// Optional build macro LINEAR_ROUND_SAT_EN: round-half-up requantisation with
// saturation to [-128,127]; without it the requant is truncating.
module linear_tile_ctrl #(
    parameter int unsigned WIDTH    = 64,
    parameter int unsigned M_ROWS   = 32,
    parameter int unsigned K_DIM    = 128,
    parameter int unsigned N_COLS   = 128,
    parameter int unsigned ACC_W    = 32,
    parameter int unsigned RD_LAT   = 7,
    parameter int unsigned ARR_LAT  = 8,
    parameter int unsigned X_BASE   = 2560,
    parameter int unsigned W_BASE   = 0,
    parameter int unsigned OUT_BASE = 3072
) (
    input  logic                                       clk,
    input  logic                                       rst_n,
    input  logic                                       start,
    input  logic [4:0]                                 shift_amt,
    output logic                                       busy,
    output logic                                       done,
    output logic [31:0]                                x_addr,
    input  logic [WIDTH-1:0]                           x_rdata,
    output logic                                       w_we,
    output logic [31:0]                                w_addr,
    output logic [WIDTH-1:0]                           w_wdata,
    input  logic [WIDTH-1:0]                           w_rdata,
    output logic [WIDTH-1:0]                           arr_row,
    output logic [WIDTH-1:0]                           arr_col,
    output logic                                       arr_valid,
    output logic                                       arr_flush,
    input  logic [(WIDTH/8)*(WIDTH/8)*ACC_W-1:0]       arr_res
);

    localparam int unsigned T   = WIDTH / 8;
    localparam int unsigned MT  = M_ROWS / T;
    localparam int unsigned NT  = N_COLS / T;
    localparam int unsigned WT  = RD_LAT + ARR_LAT;
    localparam int unsigned MTW = (MT > 1) ? $clog2(MT) : 1;
    localparam int unsigned NTW = (NT > 1) ? $clog2(NT) : 1;
    localparam int unsigned KW  = (K_DIM > 1) ? $clog2(K_DIM) : 1;
    localparam int unsigned WTW = (WT > 1) ? $clog2(WT) : 1;
    localparam int unsigned BW  = (T > 1) ? $clog2(T) : 1;

    localparam logic [MTW-1:0] MT_LAST = MTW'(MT - 1);
    localparam logic [NTW-1:0] NT_LAST = NTW'(NT - 1);
    localparam logic [KW-1:0]  K_LAST  = KW'(K_DIM - 1);
    localparam logic [WTW-1:0] WT_LAST = WTW'(WT - 1);
    localparam logic [BW-1:0]  B_LAST  = BW'(T - 1);

    typedef enum logic [2:0] {IDLE, FLUSH, READ, WAIT, WRITE} state_t;

    state_t            state;
    logic [MTW-1:0]    mt;
    logic [NTW-1:0]    nt;
    logic [KW-1:0]     k;
    logic [WTW-1:0]    wcnt;
    logic [BW-1:0]     beat;
    logic [4:0]        shift;
    logic [RD_LAT-1:0] vpipe;
    logic [BW-1:0]     nbeat;
    logic [WIDTH-1:0]  wdata_next;
    logic [31:0]       out_addr_next;

    // Accumulator to int8: arithmetic shift, then truncate or round+saturate.
    function automatic logic [7:0] requant(input logic [ACC_W-1:0] a, input logic [4:0] sh);
`ifdef LINEAR_ROUND_SAT_EN
        logic signed [ACC_W:0] ext, rnd, s, q_max;
        q_max = (ACC_W+1)'(127);
        ext   = {a[ACC_W-1], a};
        rnd   = (sh != 5'd0) ? ((ACC_W+1)'(1) << (sh - 5'd1)) : '0;
        s     = (ext + rnd) >>> sh;
        if (s > q_max)
            return 8'h7F;
        else if (s < ~q_max)
            return 8'h80;
        else
            return s[7:0];
`else
        return 8'($signed(a) >>> sh);
`endif
    endfunction

    assign arr_row   = x_rdata;
    assign arr_col   = w_rdata;
    assign arr_valid = vpipe[RD_LAT-1];

    // Data and address for the write beat that the next edge will present.
    always_comb begin
        nbeat      = (state == WRITE) ? beat + BW'(1) : '0;
        wdata_next = '0;
        for (int unsigned i = 0; i < T; i++) begin
            wdata_next[WIDTH-1-8*i -: 8] =
                requant(arr_res[(i*T + 32'(nbeat))*ACC_W +: ACC_W], shift);
        end
        out_addr_next = OUT_BASE + (32'(nt)*T + 32'(nbeat))*MT + 32'(mt);
    end

    // READ indicator delayed to line up with returning read data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vpipe <= '0;
        end else begin
            vpipe[0] <= (state == READ);
            for (int unsigned i = 1; i < RD_LAT; i++) begin
                vpipe[i] <= vpipe[i-1];
            end
        end
    end

    // Tile sequencer with registered handshake, address and write outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            mt        <= '0;
            nt        <= '0;
            k         <= '0;
            wcnt      <= '0;
            beat      <= '0;
            shift     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            w_we      <= 1'b0;
            arr_flush <= 1'b0;
            x_addr    <= X_BASE;
            w_addr    <= W_BASE;
            w_wdata   <= '0;
        end else begin
            done      <= 1'b0;
            arr_flush <= 1'b0;
            w_we      <= 1'b0;
            w_wdata   <= '0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= FLUSH;
                        shift     <= shift_amt;
                        busy      <= 1'b1;
                        arr_flush <= 1'b1;
                        mt        <= '0;
                        nt        <= '0;
                    end
                end
                FLUSH: begin
                    state  <= READ;
                    k      <= '0;
                    x_addr <= X_BASE + 32'(mt);
                    w_addr <= W_BASE + 32'(nt);
                end
                READ: begin
                    if (k == K_LAST) begin
                        state <= WAIT;
                        wcnt  <= '0;
                    end else begin
                        k      <= k + KW'(1);
                        x_addr <= x_addr + MT;
                        w_addr <= w_addr + NT;
                    end
                end
                WAIT: begin
                    if (wcnt == WT_LAST) begin
                        state   <= WRITE;
                        beat    <= '0;
                        w_we    <= 1'b1;
                        w_addr  <= out_addr_next;
                        w_wdata <= wdata_next;
                    end else begin
                        wcnt <= wcnt + WTW'(1);
                    end
                end
                WRITE: begin
                    if (beat == B_LAST) begin
                        if (mt == MT_LAST && nt == NT_LAST) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            mt    <= '0;
                            nt    <= '0;
                        end else begin
                            state     <= FLUSH;
                            arr_flush <= 1'b1;
                            if (nt == NT_LAST) begin
                                nt <= '0;
                                mt <= mt + MTW'(1);
                            end else begin
                                nt <= nt + NTW'(1);
                            end
                        end
                    end else begin
                        beat    <= beat + BW'(1);
                        w_we    <= 1'b1;
                        w_addr  <= out_addr_next;
                        w_wdata <= wdata_next;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
